// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_HALT} fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO of {pc, instr}; head, valid and full are registered.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  fetch_ent_t wdata_i,
    output fetch_ent_t head_o,
    output logic       valid_o,
    output logic       full_o
);
    logic [1:0] cnt_q, cnt_d;
    fetch_ent_t e0_q, e0_d, e1_q, e1_d;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d  = wdata_i;
                        cnt_d = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        e1_d  = wdata_i;
                        cnt_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q != 2'd0) begin
                        e0_d  = e1_q;
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever survives the pop.
                    if (cnt_q == 2'd1) begin
                        e0_d = wdata_i;
                    end else if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
            valid_o <= 1'b0;
            full_o  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            valid_o <= (cnt_d != 2'd0);
            full_o  <= (cnt_d == 2'(DEPTH));
        end
    end

    assign head_o = e0_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: FSM, fetch PC and issue logic feeding a 2-entry prefetch buffer.
// Build option FETCH_MISALIGN_CHECK_EN: misaligned redirects halt and raise a sticky fetch_err.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               busy,
    output logic               fetch_err
);
    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, tgt_pc;
    logic              err_q, busy_q, pop, issue, misalign, buf_full;
    fetch_ent_t        head;

    assign tgt_pc = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign pop   = out_valid & out_ready;
    // A full buffer can still accept a fetch when the head leaves this cycle.
    assign issue = (state_q == F_RUN) & ~redirect_valid & ~halt_req & (~buf_full | pop);

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (redirect_valid && !misalign) pc_q <= tgt_pc;
            else if (issue)                  pc_q <= pc_q + PC_STEP;

            unique case (state_q)
                F_IDLE, F_HALT: if (start && !err_q) begin
                    state_q <= F_RUN;
                    busy_q  <= 1'b1;
                end
                F_RUN: if (halt_req) begin
                    state_q <= F_HALT;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= F_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (misalign) begin
                state_q <= F_HALT;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ('{pc: pc_q, instr: imem_rdata}),
        .head_o  (head),
        .valid_o (out_valid),
        .full_o  (buf_full)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign busy      = busy_q;
    assign fetch_err = err_q;
endmodule
